imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter: XLEN, 32, immediate/datapath width; legal values 32 or 64 only.
REQ-002 SHALL provide parameter: DEPTH, 2, output buffer entries; power of two, minimum 2.
REQ-003 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port: rstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: flush  in  1  synchronous buffer clear.
REQ-006 SHALL have ports: in_valid  in  1, in_ready  out  1, in_ins  in  32; instruction input handshake.
REQ-007 SHALL have ports: out_valid  out  1, out_ready  in  1; result output handshake.
REQ-008 SHALL have ports: out_imm  out  XLEN  immediate; out_fmt  out  3  format code; out_ill  out  1  unsupported encoding; out_ins  out  32  instruction pass-through.
REQ-009 SHALL have port: level  out  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-010 SHALL encode out_fmt as follows: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM, 7 ILL.
REQ-011 SHALL decode ins[6:0]: 0000011, 1100111 and 0001111 as I (sign-extend ins[31:20]); 0100011 as S ({ins[31:25],ins[11:7]} sign-extended).
REQ-012 SHALL decode 1100011 as B ({ins[31],ins[7],ins[30:25],ins[11:8],0} sign-extended) and 1101111 as J ({ins[31],ins[19:12],ins[20],ins[30:21],0} sign-extended).
REQ-013 SHALL decode 0110111 (LUI) and 0010111 (AUIPC) as U: {ins[31:12],12'b0}, sign-extended to XLEN.
REQ-014 SHALL decode 0010011 as I, except funct3 001/101 (shifts), where imm is the zero-extended shamt: ins[24:20] when XLEN=32, ins[25:20] when XLEN=64.
REQ-015 SHALL flag ILL when XLEN=32 and a shift has ins[25]=1.
REQ-016 SHALL decode 0011011 (OP-IMM-32) as REQ-014 using a 5-bit shamt when XLEN=64, and as ILL when XLEN=32.
REQ-017 SHALL decode 0110011 as NONE with imm 0; SHALL decode 0111011 as NONE when XLEN=64 and as ILL when XLEN=32.
REQ-018 SHALL decode 1110011 by funct3: 000 gives NONE, imm 0; 001-011 give I with zero-extended ins[31:20]; 101-111 give ZIMM with zero-extended ins[19:15]; 100 gives ILL.
REQ-019 SHALL treat ins[1:0]!=2'b11 or any other opcode as ILL: out_fmt=7, out_ill=1, imm 0; out_ill SHALL be 1 only when out_fmt=7.
REQ-020 SHALL compute decode combinationally on in_ins and write it into the FIFO on a push; push = in_valid & in_ready & ~flush.
REQ-021 SHALL define pop = out_valid & out_ready & ~flush.
REQ-022 SHALL drive in_ready = (level!=DEPTH) and out_valid = (level!=0), both from registers only; no combinational path from out_ready to in_ready.
REQ-023 SHALL have latency of exactly 1 cycle: an entry pushed at edge N is visible at outputs after edge N, in FIFO order.
REQ-024 SHALL allow simultaneous push and pop when 0<level<DEPTH, with level unchanged and pointers wrapping modulo DEPTH.
REQ-025 SHALL drive out_imm/out_fmt/out_ill/out_ins from the head entry, and SHALL hold them stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive all output data to 0 when empty.
REQ-027 SHALL, on flush at an edge, set level and pointers to 0; in_valid in the flush cycle SHALL be dropped and no pop SHALL occur.

Reset
REQ-028 SHALL, on rstn=0 at any time (including mid-transfer), immediately clear pointers, level and all entries.
REQ-029 SHALL hold outputs in reset as: out_valid=0, in_ready=1, level=0, out_imm=0, out_fmt=0, out_ill=0, out_ins=0.
REQ-030 SHALL resume normal operation on the first rising edge after rstn deasserts.

Verification
REQ-031 SHALL verify JAL: XLEN=32, push 0xFFDFF06F, out_ready=1 -> next cycle out_imm=0xFFFFFFFC, fmt=5, ill=0.
REQ-032 SHALL verify sign extension: XLEN=64, push 0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF, fmt=1.
REQ-033 SHALL verify shifts and CSR: XLEN=32, 0x00309093 -> imm=3, fmt=1; 0x02009093 -> fmt=7, ill=1; 0x3002D073 -> imm=5, fmt=6.
REQ-034 SHALL verify backpressure: DEPTH=2, out_ready=0, push three instructions -> level=2, in_ready=0, third held; raise out_ready -> all three emerge in order, one per cycle.
REQ-035 SHALL verify flush: with level=2, flush=1 and in_valid=1 -> next cycle level=0, out_valid=0, input dropped.
REQ-036 SHALL verify reset: rstn=0 asynchronously with level=1 -> outputs match REQ-029 before the next edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator feeding a DEPTH-entry output buffer.
// Every output, head data included, comes straight from a register.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_ins,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_imm,
    output logic [2:0]                   out_fmt,
    output logic                         out_ill,
    output logic [31:0]                  out_ins,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_ZIMM = 3'd6;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic [31:0]     ins;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    entry_t          r_mem [DEPTH];
    entry_t          r_head;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    entry_t          w_dec;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_rd_nxt;
    logic [LW-1:0]   w_level_nxt;
    entry_t          w_head_nxt;

    assign w_funct3   = in_ins[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Immediate decode; anything not matched falls through as illegal with imm 0.
    always_comb begin
        w_imm = '0;
        w_fmt = FMT_ILL;
        if (in_ins[1:0] == 2'b11) begin
            case (in_ins[6:0])
                OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    w_imm = XLEN'($signed(in_ins[31:20]));
                    w_fmt = FMT_I;
                end
                OPC_STORE: begin
                    w_imm = XLEN'($signed({in_ins[31:25], in_ins[11:7]}));
                    w_fmt = FMT_S;
                end
                OPC_BRANCH: begin
                    w_imm = XLEN'($signed({in_ins[31], in_ins[7], in_ins[30:25],
                                           in_ins[11:8], 1'b0}));
                    w_fmt = FMT_B;
                end
                OPC_JAL: begin
                    w_imm = XLEN'($signed({in_ins[31], in_ins[19:12], in_ins[20],
                                           in_ins[30:21], 1'b0}));
                    w_fmt = FMT_J;
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_imm = XLEN'($signed({in_ins[31:12], 12'b0}));
                    w_fmt = FMT_U;
                end
                OPC_OP_IMM: begin
                    if (!w_is_shift) begin
                        w_imm = XLEN'($signed(in_ins[31:20]));
                        w_fmt = FMT_I;
                    end else if (XLEN == 64) begin
                        w_imm = XLEN'(in_ins[25:20]);
                        w_fmt = FMT_I;
                    end else if (!in_ins[25]) begin
                        w_imm = XLEN'(in_ins[24:20]);
                        w_fmt = FMT_I;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        w_imm = w_is_shift ? XLEN'(in_ins[24:20])
                                           : XLEN'($signed(in_ins[31:20]));
                        w_fmt = FMT_I;
                    end
                end
                OPC_OP: begin
                    w_fmt = FMT_NONE;
                end
                OPC_OP_32: begin
                    if (XLEN == 64) begin
                        w_fmt = FMT_NONE;
                    end
                end
                OPC_SYSTEM: begin
                    case (w_funct3)
                        3'b000: w_fmt = FMT_NONE;
                        3'b001, 3'b010, 3'b011: begin
                            w_imm = XLEN'(in_ins[31:20]);
                            w_fmt = FMT_I;
                        end
                        3'b101, 3'b110, 3'b111: begin
                            w_imm = XLEN'(in_ins[19:15]);
                            w_fmt = FMT_ZIMM;
                        end
                        default: w_fmt = FMT_ILL;
                    endcase
                end
                default: w_fmt = FMT_ILL;
            endcase
        end
    end

    always_comb begin
        w_dec     = '0;
        w_dec.ins = in_ins;
        w_dec.imm = w_imm;
        w_dec.fmt = w_fmt;
        w_dec.ill = (w_fmt == FMT_ILL);
    end

    assign w_push      = in_valid & r_in_ready & ~flush;
    assign w_pop       = r_out_valid & out_ready & ~flush;
    assign w_rd_nxt    = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    // Head after this edge: empty -> zeros, bypass when the push lands in an emptied buffer.
    always_comb begin
        w_head_nxt = '0;
        if (w_level_nxt == '0) begin
            w_head_nxt = '0;
        end else if (r_level == LW'(w_pop)) begin
            w_head_nxt = w_dec;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr    <= w_rd_nxt;
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != LW'(DEPTH));
            r_out_valid <= (w_level_nxt != '0);
            r_head      <= w_head_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign level     = r_level;
    assign out_imm   = r_head.imm;
    assign out_fmt   = r_head.fmt;
    assign out_ill   = r_head.ill;
    assign out_ins   = r_head.ins;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives a 32-bit and a 64-bit instance in lockstep and checks both against
// a queue model with an arithmetic immediate reference, plus literal vectors.
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;

    logic        clk, rstn, flush, in_valid, out_ready;
    logic [31:0] in_ins;

    logic        r32, v32, ill32;
    logic [31:0] imm32, ins32;
    logic [2:0]  fmt32;
    logic [1:0]  lvl32;

    logic        r64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] ins64;
    logic [2:0]  fmt64;
    logic [1:0]  lvl64;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) u_d32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_ins(in_ins),
        .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_ill(ill32), .out_ins(ins32),
        .level(lvl32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) u_d64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_ins(in_ins),
        .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_ill(ill64), .out_ins(ins64),
        .level(lvl64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic longint sx(input longint val, input int bits);
        if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
        return val;
    endfunction

    // Reference decode from field arithmetic; fmt codes 0..7 as NONE,I,S,B,U,J,ZIMM,ILL.
    function automatic void ref_dec(input int xl, input logic [31:0] i,
                                    output logic [63:0] imm, output int fmt);
        int     op    = int'(i[6:0]);
        int     f3    = int'(i[14:12]);
        bit     shift = (f3 == 1) || (f3 == 5);
        longint v     = 0;
        fmt = 7;
        case (op)
            'h03, 'h67, 'h0F: begin fmt = 1; v = sx(longint'(i[31:20]), 12); end
            'h23: begin fmt = 2; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
            'h63: begin
                fmt = 3;
                v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                       longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
            'h6F: begin
                fmt = 5;
                v = sx(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 +
                       longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            end
            'h37, 'h17: begin fmt = 4; v = sx(longint'(i[31:12]) * 4096, 32); end
            'h13: begin
                if (!shift) begin fmt = 1; v = sx(longint'(i[31:20]), 12); end
                else if (xl == 64) begin fmt = 1; v = longint'(i[25:20]); end
                else if (i[25] == 1'b0) begin fmt = 1; v = longint'(i[24:20]); end
            end
            'h1B: if (xl == 64) begin
                fmt = 1;
                v = shift ? longint'(i[24:20]) : sx(longint'(i[31:20]), 12);
            end
            'h33: fmt = 0;
            'h3B: if (xl == 64) fmt = 0;
            'h73: begin
                if (f3 == 0) fmt = 0;
                else if (f3 <= 3) begin fmt = 1; v = longint'(i[31:20]); end
                else if (f3 >= 5) begin fmt = 6; v = longint'(i[19:15]); end
            end
            default: fmt = 7;
        endcase
        imm = (fmt == 7) ? 64'd0 : 64'(v);
        if (xl == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Behavioural buffer: a queue of accepted instructions.
    logic [31:0] q[$];
    always @(posedge clk or negedge rstn) begin
        if (!rstn || flush) begin
            q.delete();
        end else begin
            bit p, o;
            o = (q.size() != 0) && out_ready;
            p = in_valid && (q.size() < DEPTH);
            if (o) void'(q.pop_front());
            if (p) q.push_back(in_ins);
        end
    end

    task automatic cmp(input string tag, input int xl, input logic v, input logic r,
                       input logic [1:0] lv, input logic [63:0] imm, input logic [2:0] f,
                       input logic il, input logic [31:0] ins);
        logic [63:0] ei = '0;
        logic [31:0] eins = '0;
        int          ef = 0;
        if (q.size() != 0) begin
            ref_dec(xl, q[0], ei, ef);
            eins = q[0];
        end
        chk({tag, ".out_valid"}, 64'(v), 64'(q.size() != 0));
        chk({tag, ".in_ready"}, 64'(r), 64'(q.size() != DEPTH));
        chk({tag, ".level"}, 64'(lv), 64'(q.size()));
        chk({tag, ".imm"}, imm, ei);
        chk({tag, ".fmt"}, 64'(f), 64'(ef));
        chk({tag, ".ill"}, 64'(il), 64'(ef == 7));
        chk({tag, ".ins"}, 64'(ins), 64'(eins));
    endtask

    always @(negedge clk) begin
        cmp("d32", 32, v32, r32, lvl32, {32'd0, imm32}, fmt32, ill32, ins32);
        cmp("d64", 64, v64, r64, lvl64, imm64, fmt64, ill64, ins64);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins);
        in_valid = 1'b1;
        in_ins   = ins;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc = 0;
        in_valid = 1'b1;
        in_ins   = ins;
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            acc = r32;
            step();
            if (acc) break;
        end
        chk("send.accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (lvl32 == 2'd0) break;
            step();
        end
        chk("drain.level", 64'(lvl32), 64'd0);
    endtask

    localparam int NV = 22;
    logic [31:0] vecs [NV] = '{
        32'h00812183, 32'hFE112E23, 32'hFE0008E3, 32'h800000B7, 32'h00001097,
        32'h7FF00067, 32'h0000000F, 32'h00B50533, 32'h00B5053B, 32'h0015159B,
        32'hFFF5051B, 32'h4015D59B, 32'h40B55513, 32'h00000073, 32'h30002573,
        32'hFFF0C073, 32'hFFF01073, 32'h00000013, 32'h00000012, 32'h0000007F,
        32'h00000000, 32'h87654337
    };

    logic [31:0] got[$];
    int          got_cyc[$];

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ins = '0; out_ready = 1'b0;
        repeat (2) step();
        chk("rst.level", 64'(lvl32), 64'd0);
        chk("rst.in_ready", 64'(r32), 64'd1);
        chk("rst.out_valid", 64'(v32), 64'd0);
        rstn = 1'b1;
        step();

        // Hand-computed vectors
        out_ready = 1'b1;
        push_one(32'hFFDFF06F);
        chk("jal.valid", 64'(v32), 64'd1);
        chk("jal.imm32", 64'(imm32), 64'hFFFF_FFFC);
        chk("jal.fmt", 64'(fmt32), 64'd5);
        chk("jal.ill", 64'(ill32), 64'd0);
        chk("jal.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        push_one(32'hFFF00093);
        chk("addi.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.fmt64", 64'(fmt64), 64'd1);
        push_one(32'h00309093);
        chk("slli3.imm", 64'(imm32), 64'd3);
        chk("slli3.fmt", 64'(fmt32), 64'd1);
        push_one(32'h02009093);
        chk("slli32.fmt32", 64'(fmt32), 64'd7);
        chk("slli32.ill32", 64'(ill32), 64'd1);
        chk("slli32.imm32", 64'(imm32), 64'd0);
        chk("slli32.imm64", imm64, 64'd32);
        push_one(32'h3002D073);
        chk("csrwi.imm", 64'(imm32), 64'd5);
        chk("csrwi.fmt", 64'(fmt32), 64'd6);
        drain();

        // Model-checked stream with random backpressure
        foreach (vecs[k]) send(vecs[k]);
        drain();

        // Backpressure: three pushed into a two-entry buffer
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = 32'h00100093; step();
        in_ins = 32'h00200113; step();
        in_ins = 32'h00300193; step();
        chk("bp.level", 64'(lvl32), 64'd2);
        chk("bp.in_ready", 64'(r32), 64'd0);
        chk("bp.head", 64'(ins32), 64'h00100093);
        out_ready = 1'b1;
        for (int c = 0; c < 8 && got.size() < 3; c++) begin
            bit acc;
            if (v32) begin got.push_back(ins32); got_cyc.push_back(c); end
            acc = in_valid && r32;
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("bp.count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp.order0", 64'(got[0]), 64'h00100093);
            chk("bp.order1", 64'(got[1]), 64'h00200113);
            chk("bp.order2", 64'(got[2]), 64'h00300193);
            chk("bp.back2back", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
        end
        drain();

        // Flush with a full buffer and a pending input
        out_ready = 1'b0;
        push_one(32'h00100093);
        push_one(32'h00200113);
        chk("fl.level_before", 64'(lvl32), 64'd2);
        flush = 1'b1; in_valid = 1'b1; in_ins = 32'h00400213;
        step();
        chk("fl.level", 64'(lvl32), 64'd0);
        chk("fl.valid", 64'(v32), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl.dropped", 64'(lvl32), 64'd0);

        // Flush with one entry, input ready and out_ready high: no push, no pop
        push_one(32'h00500293);
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ins = 32'h00600313;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1.level", 64'(lvl32), 64'd0);
        chk("fl1.ins", 64'(ins32), 64'd0);

        // Asynchronous reset with one entry held
        out_ready = 1'b0;
        push_one(32'hFFDFF06F);
        chk("ar.level_before", 64'(lvl32), 64'd1);
        rstn = 1'b0;
        #1;
        chk("ar.valid", 64'(v32), 64'd0);
        chk("ar.in_ready", 64'(r32), 64'd1);
        chk("ar.level", 64'(lvl32), 64'd0);
        chk("ar.imm", 64'(imm32), 64'd0);
        chk("ar.fmt", 64'(fmt32), 64'd0);
        chk("ar.ill", 64'(ill32), 64'd0);
        chk("ar.ins", 64'(ins32), 64'd0);
        chk("ar.imm64", imm64, 64'd0);
        step();
        rstn = 1'b1;
        step();
        push_one(32'h00309093);
        chk("ar.resume", 64'(imm32), 64'd3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
